// File: rtl/cs_sample_packer_fifo.sv
// Coherent-sampler byte packer with a DEPTH-entry byte FIFO in front of the
// UART sender. Each CSReq contributes NBLSB counter LSBs, packed LSB-first.
// Completed bytes are queued, and a byte is dropped only when the FIFO is
// full with no pop in the same cycle. Drops are counted with saturation.
module cs_sample_packer_fifo #(
  parameter int NBLSB = 1,
  parameter int CNTW  = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       CSReq,
  input  logic [CNTW-1:0]            CSCnt,
  input  logic                       is_transmitting,
  input  logic                       clr_ovf,
  output logic [7:0]                 tx_byte,
  output logic                       transmit,
  output logic                       overflow,
  output logic [15:0]                drop_cnt,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int NBIT = 8 / NBLSB;
  localparam int ITW  = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;

  if (!(NBLSB == 1 || NBLSB == 2 || NBLSB == 4 || NBLSB == 8)) begin : g_bad_nblsb
    $error("cs_sample_packer_fifo: NBLSB must be 1, 2, 4 or 8");
  end
  if (CNTW < NBLSB) begin : g_bad_cntw
    $error("cs_sample_packer_fifo: CNTW must be >= NBLSB");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cs_sample_packer_fifo: DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  // Saturating increment for the drop counter: sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [ITW-1:0] it_q, it_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     byte_w;
  logic [7:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           overflow_q, overflow_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  logic [15:0]    drop_base;
  state_t         state_q;
  logic [7:0]     tx_byte_q;
  logic           transmit_q;
  logic           complete;
  logic           pop;
  logic           push_ok;
  logic           drop;

  // Only the low NBLSB counter bits are ever used.
  wire unused_cnt = ^CSCnt;

  // Packer: merge the current sample into the shift byte and advance the iteration.
  always_comb begin
    byte_w = shift_q;
    for (int k = 0; k < NBIT; k++) begin
      if (it_q == ITW'(k)) byte_w[k*NBLSB +: NBLSB] = CSCnt[NBLSB-1:0];
    end
    complete = CSReq && (it_q == ITW'(NBIT - 1));
    it_d     = it_q;
    shift_d  = shift_q;
    if (CSReq) begin
      shift_d = byte_w;
      it_d    = complete ? '0 : it_q + ITW'(1);
    end
  end

  // FIFO bookkeeping: push/pop arbitration, level, pointers and drop accounting.
  always_comb begin
    pop      = (state_q == IDLE) && (level_q != '0) && !is_transmitting;
    push_ok  = complete && ((level_q < LW'(DEPTH)) || pop);
    drop     = complete && !push_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    drop_base  = clr_ovf ? 16'd0 : drop_cnt_q;
    overflow_d = clr_ovf ? 1'b0 : overflow_q;
    drop_cnt_d = drop_base;
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc16(drop_base);
    end
  end

  // Control state registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      it_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      it_q       <= it_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Data storage: shift byte and FIFO array carry no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push_ok) mem_q[wr_ptr_q] <= byte_w;
  end

  // Output FSM: pop into tx_byte, one-cycle transmit strobe, then a guard cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_byte_q  <= 8'd0;
      transmit_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          transmit_q <= 1'b0;
          if (pop) begin
            tx_byte_q  <= mem_q[rd_ptr_q];
            transmit_q <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          transmit_q <= 1'b0;
          state_q    <= HOLD;
        end
        HOLD: begin
          transmit_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          transmit_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_byte    = tx_byte_q;
  assign transmit   = transmit_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_cs_sample_packer_fifo.sv
// Directed bench for cs_sample_packer_fifo: four instances cover NBLSB = 1, 2,
// 4, 8; the NBLSB = 8 instance uses DEPTH = 4 for overflow scenarios.
module tb_cs_sample_packer_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // NBLSB = 1, DEPTH = 16
  logic req1 = 0, busy1 = 0, clr1 = 0;
  logic [15:0] cnt1 = '0;
  logic [7:0] tx1; logic trn1, ovf1; logic [15:0] dc1; logic [4:0] lvl1;
  // NBLSB = 2, DEPTH = 16
  logic req2 = 0, busy2 = 0, clr2 = 0;
  logic [15:0] cnt2 = '0;
  logic [7:0] tx2; logic trn2, ovf2; logic [15:0] dc2; logic [4:0] lvl2;
  // NBLSB = 4, DEPTH = 16
  logic req4 = 0, busy4 = 0, clr4 = 0;
  logic [15:0] cnt4 = '0;
  logic [7:0] tx4; logic trn4, ovf4; logic [15:0] dc4; logic [4:0] lvl4;
  // NBLSB = 8, DEPTH = 4
  logic req8 = 0, busy8 = 0, clr8 = 0;
  logic [15:0] cnt8 = '0;
  logic [7:0] tx8; logic trn8, ovf8; logic [15:0] dc8; logic [2:0] lvl8;

  cs_sample_packer_fifo #(.NBLSB(1), .CNTW(16), .DEPTH(16)) u1 (
    .clk(clk), .rst(rst), .CSReq(req1), .CSCnt(cnt1), .is_transmitting(busy1),
    .clr_ovf(clr1), .tx_byte(tx1), .transmit(trn1), .overflow(ovf1),
    .drop_cnt(dc1), .fifo_level(lvl1));
  cs_sample_packer_fifo #(.NBLSB(2), .CNTW(16), .DEPTH(16)) u2 (
    .clk(clk), .rst(rst), .CSReq(req2), .CSCnt(cnt2), .is_transmitting(busy2),
    .clr_ovf(clr2), .tx_byte(tx2), .transmit(trn2), .overflow(ovf2),
    .drop_cnt(dc2), .fifo_level(lvl2));
  cs_sample_packer_fifo #(.NBLSB(4), .CNTW(16), .DEPTH(16)) u4 (
    .clk(clk), .rst(rst), .CSReq(req4), .CSCnt(cnt4), .is_transmitting(busy4),
    .clr_ovf(clr4), .tx_byte(tx4), .transmit(trn4), .overflow(ovf4),
    .drop_cnt(dc4), .fifo_level(lvl4));
  cs_sample_packer_fifo #(.NBLSB(8), .CNTW(16), .DEPTH(4)) u8 (
    .clk(clk), .rst(rst), .CSReq(req8), .CSCnt(cnt8), .is_transmitting(busy8),
    .clr_ovf(clr8), .tx_byte(tx8), .transmit(trn8), .overflow(ovf8),
    .drop_cnt(dc8), .fifo_level(lvl8));

  logic [7:0] got8[$];

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sender model for u8: goes busy after each transmit for 3 cycles, fixed window.
  task automatic drain8(input int cycles);
    int hold;
    hold = 0;
    got8.delete();
    busy8 = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (trn8) begin
        got8.push_back(tx8);
        busy8 = 1'b1;
        hold = 3;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) busy8 = 1'b0;
      end
    end
    busy8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (tx1 !== 8'h00) begin errors++; $display("FAIL reset_tx1: got %h expected 00", tx1); end
    checks++; if (trn1 !== 1'b0) begin errors++; $display("FAIL reset_trn1: got %b expected 0", trn1); end
    checks++; if (lvl1 !== 5'd0) begin errors++; $display("FAIL reset_lvl1: got %0d expected 0", lvl1); end
    checks++; if (ovf8 !== 1'b0 || dc8 !== 16'd0) begin errors++;
      $display("FAIL reset_ovf8: got ovf=%b dc=%h expected 0 0000", ovf8, dc8); end
    checks++; if (lvl8 !== 3'd0 || tx8 !== 8'h00) begin errors++;
      $display("FAIL reset_u8: got lvl=%0d tx=%h expected 0 00", lvl8, tx8); end
  endtask

  task automatic test_pack1();
    logic [7:0] bits;
    bits = 8'b1000_1101;  // samples 1,0,1,1,0,0,0,1 first-to-last
    busy1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req1 = 1'b1; cnt1 = {15'h1234, bits[i]};
      tick();
    end
    req1 = 1'b0;
    checks++; if (lvl1 !== 5'd1 || trn1 !== 1'b0) begin errors++;
      $display("FAIL pack1_t1: got lvl=%0d trn=%b expected 1 0", lvl1, trn1); end
    tick();
    checks++; if (trn1 !== 1'b1 || tx1 !== 8'h8D) begin errors++;
      $display("FAIL pack1_t2: got trn=%b tx=%h expected 1 8d", trn1, tx1); end
    tick();
    checks++; if (trn1 !== 1'b0 || lvl1 !== 5'd0 || tx1 !== 8'h8D) begin errors++;
      $display("FAIL pack1_t3: got trn=%b lvl=%0d tx=%h expected 0 0 8d", trn1, lvl1, tx1); end
  endtask

  task automatic test_pack_widths();
    for (int i = 0; i < 4; i++) begin
      req2 = 1'b1; cnt2 = 16'hFF00 | 16'(i);
      tick();
    end
    req2 = 1'b0;
    tick();
    checks++; if (trn2 !== 1'b1 || tx2 !== 8'hE4) begin errors++;
      $display("FAIL pack2: got trn=%b tx=%h expected 1 e4", trn2, tx2); end
    req4 = 1'b1; cnt4 = 16'h00A3; tick();
    req4 = 1'b1; cnt4 = 16'h0F5C; tick();
    req4 = 1'b0;
    tick();
    checks++; if (trn4 !== 1'b1 || tx4 !== 8'hC3) begin errors++;
      $display("FAIL pack4: got trn=%b tx=%h expected 1 c3", trn4, tx4); end
    busy8 = 1'b0;
    req8 = 1'b1; cnt8 = 16'h1234; tick();
    req8 = 1'b0;
    tick();
    checks++; if (trn8 !== 1'b1 || tx8 !== 8'h34) begin errors++;
      $display("FAIL pack8: got trn=%b tx=%h expected 1 34", trn8, tx8); end
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back();
    int pos[$];
    logic [7:0] val[$];
    busy8 = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      req8 = (n <= 3);
      cnt8 = 16'h00A0 + 16'(n);
      tick();
      if (trn8) begin pos.push_back(n); val.push_back(tx8); end
    end
    req8 = 1'b0;
    checks++; if (pos.size() != 3) begin errors++;
      $display("FAIL b2b_count: got %0d pulses expected 3", pos.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (pos[k] != 2 + 3*k || val[k] !== 8'hA1 + 8'(k)) begin errors++;
          $display("FAIL b2b_pulse%0d: got cycle %0d byte %h expected cycle %0d byte %h",
                   k, pos[k], val[k], 2 + 3*k, 8'hA1 + 8'(k)); end
      end
    end
  endtask

  task automatic test_overflow();
    busy8 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      req8 = 1'b1; cnt8 = 16'h5500 | 16'(i);
      tick();
    end
    req8 = 1'b0;
    checks++; if (lvl8 !== 3'd4 || ovf8 !== 1'b1 || dc8 !== 16'd2) begin errors++;
      $display("FAIL ovf_state: got lvl=%0d ovf=%b dc=%0d expected 4 1 2", lvl8, ovf8, dc8); end
    drain8(60);
    checks++; if (got8.size() != 4) begin errors++;
      $display("FAIL ovf_drain_count: got %0d bytes expected 4", got8.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (got8[k] !== 8'(k + 1)) begin errors++;
          $display("FAIL ovf_order%0d: got %h expected %h", k, got8[k], 8'(k + 1)); end
      end
    end
    checks++; if (lvl8 !== 3'd0) begin errors++;
      $display("FAIL ovf_empty: got lvl=%0d expected 0", lvl8); end
  endtask

  task automatic test_full_pop();
    clr8 = 1'b1; tick(); clr8 = 1'b0;
    checks++; if (ovf8 !== 1'b0 || dc8 !== 16'd0) begin errors++;
      $display("FAIL clr: got ovf=%b dc=%0d expected 0 0", ovf8, dc8); end
    busy8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req8 = 1'b1; cnt8 = 16'h0011 + 16'(i);
      tick();
    end
    req8 = 1'b0;
    tick();
    checks++; if (lvl8 !== 3'd4) begin errors++;
      $display("FAIL full_level: got %0d expected 4", lvl8); end
    busy8 = 1'b0; req8 = 1'b1; cnt8 = 16'h0015;
    tick();
    req8 = 1'b0; busy8 = 1'b1;
    checks++; if (lvl8 !== 3'd4 || dc8 !== 16'd0 || ovf8 !== 1'b0) begin errors++;
      $display("FAIL full_pop: got lvl=%0d dc=%0d ovf=%b expected 4 0 0", lvl8, dc8, ovf8); end
    checks++; if (trn8 !== 1'b1 || tx8 !== 8'h11) begin errors++;
      $display("FAIL full_pop_tx: got trn=%b tx=%h expected 1 11", trn8, tx8); end
    drain8(60);
    checks++; if (got8.size() != 4) begin errors++;
      $display("FAIL full_pop_drain: got %0d bytes expected 4", got8.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (got8[k] !== 8'h12 + 8'(k)) begin errors++;
          $display("FAIL full_pop_order%0d: got %h expected %h", k, got8[k], 8'h12 + 8'(k)); end
      end
    end
  endtask

  task automatic test_saturation();
    busy8 = 1'b1;
    req8 = 1'b1; cnt8 = 16'h00EE;
    for (int i = 0; i < 4 + 65535; i++) tick();
    req8 = 1'b0;
    checks++; if (dc8 !== 16'hFFFF || ovf8 !== 1'b1 || lvl8 !== 3'd4) begin errors++;
      $display("FAIL sat_reach: got dc=%h ovf=%b lvl=%0d expected ffff 1 4", dc8, ovf8, lvl8); end
    req8 = 1'b1; tick(); req8 = 1'b0;
    checks++; if (dc8 !== 16'hFFFF) begin errors++;
      $display("FAIL sat_hold: got %h expected ffff", dc8); end
    req8 = 1'b1; clr8 = 1'b1; tick(); req8 = 1'b0;
    checks++; if (ovf8 !== 1'b1 || dc8 !== 16'd1) begin errors++;
      $display("FAIL clr_vs_drop: got ovf=%b dc=%0d expected 1 1", ovf8, dc8); end
    tick(); clr8 = 1'b0;
    checks++; if (ovf8 !== 1'b0 || dc8 !== 16'd0) begin errors++;
      $display("FAIL clr_only: got ovf=%b dc=%0d expected 0 0", ovf8, dc8); end
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] bits;
    int npulse, where;
    logic [7:0] seen;
    busy1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req1 = 1'b1; cnt1 = 16'(i);
      tick();
    end
    req1 = 1'b0;
    checks++; if (lvl1 !== 5'd2) begin errors++;
      $display("FAIL rst_pre_level: got %0d expected 2", lvl1); end
    for (int i = 0; i < 3; i++) begin
      req1 = 1'b1; cnt1 = 16'h0001;
      tick();
    end
    req1 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tx1 !== 8'h00 || trn1 !== 1'b0 || ovf1 !== 1'b0 || dc1 !== 16'd0 || lvl1 !== 5'd0)
      begin errors++;
      $display("FAIL rst_mid_outputs: got tx=%h trn=%b ovf=%b dc=%0d lvl=%0d expected all 0",
               tx1, trn1, ovf1, dc1, lvl1); end
    checks++; if (lvl8 !== 3'd0 || ovf8 !== 1'b0) begin errors++;
      $display("FAIL rst_mid_u8: got lvl=%0d ovf=%b expected 0 0", lvl8, ovf8); end
    busy1 = 1'b0; busy8 = 1'b0;
    bits = 8'b0111_0010;  // samples 0,1,0,0,1,1,1,0 first-to-last
    npulse = 0; where = 0; seen = 8'h00;
    for (int n = 1; n <= 20; n++) begin
      req1 = (n <= 8);
      cnt1 = (n <= 8) ? {15'h0, bits[n-1]} : 16'h0;
      tick();
      if (trn1) begin npulse++; where = n; seen = tx1; end
    end
    req1 = 1'b0;
    checks++; if (npulse != 1) begin errors++;
      $display("FAIL rst_fresh_count: got %0d pulses expected 1", npulse); end
    checks++; if (seen !== 8'h72 || where != 9) begin errors++;
      $display("FAIL rst_fresh_byte: got %h at cycle %0d expected 72 at cycle 9", seen, where); end
  endtask

  initial begin
    test_reset();
    test_pack1();
    test_pack_widths();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_saturation();
    test_reset_midbyte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
